robot_controller: RTL and testbench

//  Decision side of the Mundo world/robot interface. Mundo presents sensors and executes

---
 rtl/robot_controller.sv | 172 +++++++++++++++++
 tb/tb_robot_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/robot_controller.sv
// Step-by-step decision logic for the Mundo robot: one sensor sample in, one action out.
// Left-hand wall following with dirt cleaning, heading tracking and trap latching.
//
// state      | meaning
// SEARCH     | no wall found yet, drive straight until blocked
// FOLLOW     | keeping a wall on the left
// AFTER_LEFT | just turned left around a corner, try to step into the opening
// CLEAN      | busy cleaning, samples refused until the clean timer expires
// HALT       | trap detected, frozen until reset
module robot_controller #(
  parameter int CLEAN_CYCLES = 4,
  parameter int TRAP_TURNS   = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_valid,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  output logic             ctrl_ready,
  output logic             action_valid,
  output logic             act_move,
  output logic             act_turn_left,
  output logic             act_turn_right,
  output logic             act_clean,
  output logic [1:0]       heading,
  output logic             trapped,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {SEARCH, FOLLOW, AFTER_LEFT, CLEAN, HALT} state_t;

  localparam int TW = $clog2(TRAP_TURNS + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  localparam logic [1:0] H_N = 2'b00;
  localparam logic [1:0] H_S = 2'b01;
  localparam logic [1:0] H_E = 2'b10;
  localparam logic [1:0] H_W = 2'b11;

  state_t        state;
  state_t        ret_state;
  state_t        nxt_state;
  logic [TW-1:0] turn_cnt;
  logic [CW-1:0] clean_tmr;
  logic          dec_move;
  logic          dec_left;
  logic          dec_right;
  logic          dec_clean;
  logic          accept;
  logic          trap_hit;

  function automatic logic [1:0] rot_right(input logic [1:0] h);
    case (h)
      H_N:     return H_E;
      H_E:     return H_S;
      H_S:     return H_W;
      default: return H_N;
    endcase
  endfunction

  function automatic logic [1:0] rot_left(input logic [1:0] h);
    case (h)
      H_N:     return H_W;
      H_W:     return H_S;
      H_S:     return H_E;
      default: return H_N;
    endcase
  endfunction

  always_comb begin
    dec_move  = 1'b0;
    dec_left  = 1'b0;
    dec_right = 1'b0;
    dec_clean = 1'b0;
    nxt_state = state;
    if (under) begin
      dec_clean = 1'b1;
      nxt_state = CLEAN;
    end else begin
      case (state)
        SEARCH: begin
          if (!head) dec_move = 1'b1;
          else begin
            dec_right = 1'b1;
            nxt_state = FOLLOW;
          end
        end
        FOLLOW: begin
          if (!left) begin
            dec_left  = 1'b1;
            nxt_state = AFTER_LEFT;
          end else if (!head) dec_move = 1'b1;
          else dec_right = 1'b1;
        end
        AFTER_LEFT: begin
          nxt_state = FOLLOW;
          if (!head) dec_move = 1'b1;
          else dec_right = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Trap fires on the right turn that brings the counter up to TRAP_TURNS.
  assign trap_hit = dec_right && (turn_cnt == TW'(TRAP_TURNS - 1));
  assign accept   = sensor_valid && ctrl_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= SEARCH;
      ret_state      <= SEARCH;
      ctrl_ready     <= 1'b1;
      action_valid   <= 1'b0;
      act_move       <= 1'b0;
      act_turn_left  <= 1'b0;
      act_turn_right <= 1'b0;
      act_clean      <= 1'b0;
      heading        <= H_N;
      trapped        <= 1'b0;
      move_count     <= '0;
      turn_cnt       <= '0;
      clean_tmr      <= '0;
    end else begin
      action_valid   <= 1'b0;
      act_move       <= 1'b0;
      act_turn_left  <= 1'b0;
      act_turn_right <= 1'b0;
      act_clean      <= 1'b0;
      case (state)
        CLEAN: begin
          if (clean_tmr != '0) clean_tmr <= clean_tmr - 1'b1;
          else begin
            state      <= ret_state;
            ctrl_ready <= 1'b1;
          end
        end
        HALT: ctrl_ready <= 1'b0;
        default: begin
          if (accept) begin
            action_valid   <= 1'b1;
            act_move       <= dec_move;
            act_turn_left  <= dec_left;
            act_turn_right <= dec_right;
            act_clean      <= dec_clean;
            ctrl_ready     <= 1'b0;
            state          <= trap_hit ? HALT : nxt_state;
            trapped        <= trap_hit;
            if (dec_move) begin
              turn_cnt <= '0;
              if (move_count != '1) move_count <= move_count + 1'b1;
            end
            if (dec_right) begin
              turn_cnt <= turn_cnt + 1'b1;
              heading  <= rot_right(heading);
            end
            if (dec_left) heading <= rot_left(heading);
            if (dec_clean) begin
              ret_state <= state;
              clean_tmr <= CW'(CLEAN_CYCLES);
            end
          end else begin
            ctrl_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robot_controller.sv
// Directed bench for robot_controller: wall following, cleaning, trap latch, async reset, saturation.
module tb_robot_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sensor_valid = 1'b0;
  logic        head = 1'b0;
  logic        left = 1'b0;
  logic        under = 1'b0;
  logic        ctrl_ready, action_valid, act_move, act_turn_left, act_turn_right, act_clean;
  logic [1:0]  heading;
  logic        trapped;
  logic [15:0] move_count;
  logic        s_ready, s_valid, s_move, s_tl, s_tr, s_clean, s_trapped;
  logic [1:0]  s_heading;
  logic [1:0]  s_count;
  logic [4:0]  act_vec;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] A_NONE  = 5'b00000;
  localparam logic [4:0] A_MOVE  = 5'b11000;
  localparam logic [4:0] A_LEFT  = 5'b10100;
  localparam logic [4:0] A_RIGHT = 5'b10010;
  localparam logic [4:0] A_CLEAN = 5'b10001;

  always #5 clock = ~clock;

  assign act_vec = {action_valid, act_move, act_turn_left, act_turn_right, act_clean};

  robot_controller dut (
    .clock(clock), .reset(reset), .sensor_valid(sensor_valid),
    .head(head), .left(left), .under(under),
    .ctrl_ready(ctrl_ready), .action_valid(action_valid), .act_move(act_move),
    .act_turn_left(act_turn_left), .act_turn_right(act_turn_right), .act_clean(act_clean),
    .heading(heading), .trapped(trapped), .move_count(move_count)
  );

  robot_controller #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .sensor_valid(sensor_valid),
    .head(head), .left(left), .under(under),
    .ctrl_ready(s_ready), .action_valid(s_valid), .act_move(s_move),
    .act_turn_left(s_tl), .act_turn_right(s_tr), .act_clean(s_clean),
    .heading(s_heading), .trapped(s_trapped), .move_count(s_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted sample: action one clock later, then the idle cycle after it.
  task automatic send(input logic h, input logic l, input logic u,
                      input logic [4:0] exp, input logic exp_rdy, input string tag);
    @(negedge clock);
    head = h; left = l; under = u; sensor_valid = 1'b1;
    @(posedge clock); #1;
    sensor_valid = 1'b0;
    chk({tag, "_act"}, 16'(act_vec), 16'(exp));
    chk({tag, "_rdy_low"}, 16'(ctrl_ready), 16'd0);
    @(posedge clock); #1;
    chk({tag, "_idle"}, 16'(act_vec), 16'(A_NONE));
    chk({tag, "_rdy"}, 16'(ctrl_ready), 16'(exp_rdy));
  endtask

  initial begin
    // T1 reset
    repeat (3) @(posedge clock);
    #1;
    chk("t1_heading", 16'(heading), 16'd0);
    chk("t1_ready", 16'(ctrl_ready), 16'd1);
    chk("t1_trapped", 16'(trapped), 16'd0);
    chk("t1_count", move_count, 16'd0);
    chk("t1_act", 16'(act_vec), 16'(A_NONE));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t1_act_rel", 16'(act_vec), 16'(A_NONE));

    // T2 search
    send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t2_m1");
    send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t2_m2");
    send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t2_m3");
    send(1'b1, 1'b1, 1'b0, A_RIGHT, 1'b1, "t2_tr");
    chk("t2_heading", 16'(heading), 16'b10);
    chk("t2_count", move_count, 16'd3);

    // T3 follow / after_left
    send(1'b1, 1'b0, 1'b0, A_LEFT, 1'b1, "t3_tl");
    chk("t3_heading_tl", 16'(heading), 16'b00);
    send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t3_mv");
    send(1'b1, 1'b0, 1'b0, A_LEFT, 1'b1, "t3_tl2");
    chk("t3_heading_w", 16'(heading), 16'b11);
    send(1'b1, 1'b0, 1'b0, A_RIGHT, 1'b1, "t3_al_tr");
    chk("t3_heading_n", 16'(heading), 16'b00);

    // T4 clean: ready low for the action cycle plus four clean clocks
    send(1'b0, 1'b1, 1'b1, A_CLEAN, 1'b0, "t4_clean");
    chk("t4_heading", 16'(heading), 16'b00);
    @(negedge clock);
    head = 1'b0; under = 1'b1; sensor_valid = 1'b1;
    @(posedge clock); #1;
    sensor_valid = 1'b0;
    chk("t4_ignored", 16'(act_vec), 16'(A_NONE));
    chk("t4_rdy3", 16'(ctrl_ready), 16'd0);
    @(posedge clock); #1;
    chk("t4_rdy4", 16'(ctrl_ready), 16'd0);
    @(posedge clock); #1;
    chk("t4_rdy5", 16'(ctrl_ready), 16'd0);
    chk("t4_no_act", 16'(act_vec), 16'(A_NONE));
    @(posedge clock); #1;
    chk("t4_rdy_back", 16'(ctrl_ready), 16'd1);
    send(1'b0, 1'b0, 1'b0, A_LEFT, 1'b1, "t4_resume");
    chk("t4_heading_w", 16'(heading), 16'b11);
    send(1'b0, 1'b0, 1'b0, A_MOVE, 1'b1, "t4_mv");
    chk("t4_count", move_count, 16'd5);

    // T5 trap: four right turns from west
    send(1'b1, 1'b1, 1'b0, A_RIGHT, 1'b1, "t5_r1");
    chk("t5_h1", 16'(heading), 16'b00);
    send(1'b1, 1'b1, 1'b0, A_RIGHT, 1'b1, "t5_r2");
    chk("t5_h2", 16'(heading), 16'b10);
    send(1'b1, 1'b1, 1'b0, A_RIGHT, 1'b1, "t5_r3");
    chk("t5_h3", 16'(heading), 16'b01);
    chk("t5_not_trapped", 16'(trapped), 16'd0);
    send(1'b1, 1'b1, 1'b0, A_RIGHT, 1'b0, "t5_r4");
    chk("t5_h4", 16'(heading), 16'b11);
    chk("t5_trapped", 16'(trapped), 16'd1);
    @(negedge clock);
    head = 1'b0; left = 1'b1; sensor_valid = 1'b1;
    @(posedge clock); #1;
    sensor_valid = 1'b0;
    chk("t5_halt_act", 16'(act_vec), 16'(A_NONE));
    @(posedge clock); #1;
    chk("t5_halt_act2", 16'(act_vec), 16'(A_NONE));
    chk("t5_halt_rdy", 16'(ctrl_ready), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_rst_trapped", 16'(trapped), 16'd0);
    chk("t5_rst_rdy", 16'(ctrl_ready), 16'd1);
    @(negedge clock);
    reset = 1'b0;

    // T6 async reset inside CLEAN and inside an action cycle
    send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t6_pre_mv");
    send(1'b1, 1'b0, 1'b0, A_RIGHT, 1'b1, "t6_pre_tr");
    send(1'b0, 1'b1, 1'b1, A_CLEAN, 1'b0, "t6_clean");
    #2 reset = 1'b1;
    #1;
    chk("t6_cl_rdy", 16'(ctrl_ready), 16'd1);
    chk("t6_cl_heading", 16'(heading), 16'd0);
    chk("t6_cl_count", move_count, 16'd0);
    chk("t6_cl_act", 16'(act_vec), 16'(A_NONE));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    head = 1'b0; left = 1'b1; under = 1'b0; sensor_valid = 1'b1;
    @(posedge clock); #1;
    sensor_valid = 1'b0;
    chk("t6_act_mv", 16'(act_vec), 16'(A_MOVE));
    #2 reset = 1'b1;
    #1;
    chk("t6_act_drop", 16'(act_vec), 16'(A_NONE));
    chk("t6_act_count", move_count, 16'd0);
    chk("t6_act_rdy", 16'(ctrl_ready), 16'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t6_no_replay", 16'(act_vec), 16'(A_NONE));
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b0, A_MOVE, 1'b1, "t6_sat_mv");
    chk("t6_count16", move_count, 16'd5);
    chk("t6_count_sat", 16'(s_count), 16'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
